// File: rtl/crc_pkg.sv
// crc_pkg: shared types and crc8_wcdma defaults for the serial CRC blocks.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RX,
        CHECK
    } state_e;

    localparam int unsigned CRC_BITS    = 8;
    localparam logic [7:0]  CRC_POLY    = 8'h9B;
    localparam logic [7:0]  CRC_INIT    = 8'h00;
    localparam logic [7:0]  CRC_XOR_OUT = 8'h00;
    localparam bit          CRC_REF_OUT = 1'b1;

endpackage

// File: rtl/crc.sv
// crc: bit-serial direct-method CRC engine with optional output reflection and final XOR.
module crc
    import crc_pkg::*;
#(
    parameter int unsigned     BITS    = CRC_BITS,
    parameter logic [BITS-1:0] POLY    = CRC_POLY,
    parameter logic [BITS-1:0] INIT    = CRC_INIT,
    parameter logic [BITS-1:0] XOR_OUT = CRC_XOR_OUT,
    parameter bit              REF_OUT = CRC_REF_OUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            din,
    output logic [BITS-1:0] crc_out
);

    logic [BITS-1:0] crc_q;
    logic [BITS-1:0] crc_d;
    logic [BITS-1:0] crc_ref;
    logic            fb;

    assign fb = crc_q[BITS-1] ^ din;

    always_comb begin
        crc_d = crc_q;
        if (en) begin
            crc_d = {crc_q[BITS-2:0], 1'b0} ^ (fb ? POLY : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    always_comb begin
        crc_ref = '0;
        for (int i = 0; i < BITS; i++) begin
            crc_ref[i] = crc_q[BITS-1-i];
        end
    end

    assign crc_out = (REF_OUT ? crc_ref : crc_q) ^ XOR_OUT;

endmodule

// File: rtl/crc_frame_checker.sv
// crc_frame_checker: serial frame receiver that checks the trailing CRC field.
// Define CRC_FRAME_CHECKER_STATS_EN to add good_cnt/bad_cnt frame counters.
module crc_frame_checker
    import crc_pkg::*;
#(
    parameter int unsigned     BITS    = CRC_BITS,
    parameter logic [BITS-1:0] POLY    = CRC_POLY,
    parameter logic [BITS-1:0] INIT    = CRC_INIT,
    parameter logic [BITS-1:0] XOR_OUT = CRC_XOR_OUT,
    parameter bit              REF_OUT = CRC_REF_OUT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_data,
    input  logic            in_sof,
    input  logic            in_eof,
    output logic            frame_done,
    output logic            crc_ok,
    output logic            runt,
    output logic [BITS-1:0] crc_rx,
    output logic [BITS-1:0] crc_calc
`ifdef CRC_FRAME_CHECKER_STATS_EN
    ,
    output logic [15:0]     good_cnt,
    output logic [15:0]     bad_cnt
`endif
);

    localparam int unsigned   CW       = $clog2(BITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BITS);

    state_e          state_q;
    state_e          state_d;
    logic [BITS-1:0] sr_q;
    logic [BITS-1:0] sr_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic            done_q;
    logic            done_d;
    logic            ok_q;
    logic            ok_d;
    logic            runt_q;
    logic            runt_d;
    logic [BITS-1:0] crc_rx_q;
    logic [BITS-1:0] crc_rx_d;
    logic [BITS-1:0] crc_calc_q;
    logic [BITS-1:0] crc_calc_d;

    logic            sof_acc;
    logic            bit_acc;
    logic            eof_acc;
    logic            eng_en;
    logic            eng_rst;
    logic [BITS-1:0] calc_w;

    assign sof_acc = in_valid & in_sof;
    assign bit_acc = in_valid & (in_sof | (state_q == RX));
    assign eof_acc = bit_acc & in_eof;
    // Only bits pushed out of a full delay line are payload.
    assign eng_en  = bit_acc & ~sof_acc & (cnt_q == CNT_FULL);
    assign eng_rst = rst | sof_acc;

    crc #(
        .BITS    (BITS),
        .POLY    (POLY),
        .INIT    (INIT),
        .XOR_OUT (XOR_OUT),
        .REF_OUT (REF_OUT)
    ) u_crc (
        .clk     (clk),
        .rst     (eng_rst),
        .en      (eng_en),
        .din     (sr_q[BITS-1]),
        .crc_out (calc_w)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        if (sof_acc) begin
            sr_d  = {{(BITS-1){1'b0}}, in_data};
            cnt_d = CW'(1);
        end else if (bit_acc) begin
            sr_d = {sr_q[BITS-2:0], in_data};
            if (cnt_q != CNT_FULL) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (eof_acc) begin
            state_d = CHECK;
        end else if (sof_acc) begin
            state_d = RX;
        end else if (state_q == CHECK) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        done_d     = (state_q == CHECK);
        ok_d       = ok_q;
        runt_d     = runt_q;
        crc_rx_d   = crc_rx_q;
        crc_calc_d = crc_calc_q;
        if (done_d) begin
            runt_d     = (cnt_q != CNT_FULL);
            crc_rx_d   = sr_q;
            crc_calc_d = calc_w;
            ok_d       = (cnt_q == CNT_FULL) && (sr_q == calc_w);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            ok_q       <= 1'b0;
            runt_q     <= 1'b0;
            crc_rx_q   <= '0;
            crc_calc_q <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            ok_q       <= ok_d;
            runt_q     <= runt_d;
            crc_rx_q   <= crc_rx_d;
            crc_calc_q <= crc_calc_d;
        end
    end

    assign frame_done = done_q;
    assign crc_ok     = ok_q;
    assign runt       = runt_q;
    assign crc_rx     = crc_rx_q;
    assign crc_calc   = crc_calc_q;

`ifdef CRC_FRAME_CHECKER_STATS_EN
    logic [15:0] good_q;
    logic [15:0] good_d;
    logic [15:0] bad_q;
    logic [15:0] bad_d;

    // Counts update on the same edge the result is published.
    always_comb begin
        good_d = good_q;
        bad_d  = bad_q;
        if (done_d) begin
            if (ok_d) begin
                if (good_q != 16'hFFFF) begin
                    good_d = good_q + 16'd1;
                end
            end else begin
                if (bad_q != 16'hFFFF) begin
                    bad_d = bad_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            good_q <= good_d;
            bad_q  <= bad_d;
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`endif

endmodule

// File: tb/tb_crc_frame_checker.sv
// tb_crc_frame_checker: random framed bit streams checked against a polynomial-division model.
module tb_crc_frame_checker;

    localparam int         BITS    = 8;
    localparam logic [7:0] POLY    = 8'h9B;
    localparam logic [7:0] INIT    = 8'h00;
    localparam logic [7:0] XOR_OUT = 8'h00;
    localparam bit         REF_OUT = 1'b1;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_data;
    logic       in_sof;
    logic       in_eof;
    logic       frame_done;
    logic       crc_ok;
    logic       runt;
    logic [7:0] crc_rx;
    logic [7:0] crc_calc;
`ifdef CRC_FRAME_CHECKER_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    crc_frame_checker dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .in_eof     (in_eof),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .runt       (runt),
        .crc_rx     (crc_rx),
        .crc_calc   (crc_calc)
`ifdef CRC_FRAME_CHECKER_STATS_EN
        ,
        .good_cnt   (good_cnt),
        .bad_cnt    (bad_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_bad  = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    bit cur[$];
    bit fr[$];
    bit in_frame = 1'b0;
    bit pend     = 1'b0;

    logic       e_done = 1'b0;
    logic       e_ok   = 1'b0;
    logic       e_runt = 1'b0;
    logic [7:0] e_rx   = 8'h00;
    logic [7:0] e_calc = 8'h00;
    int         e_good = 0;
    int         e_bad  = 0;
    logic       p_ok;
    logic       p_runt;
    logic [7:0] p_rx;
    logic [7:0] p_calc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_ne(input string nm, input logic [31:0] act, input logic [31:0] bad);
        n_cmp++;
        if (act === bad) begin
            n_bad++;
            $display("FAIL %s: got %0h want anything but %0h", nm, act, bad);
        end
    endtask

    // CRC as the remainder of the augmented message divided by x^8+POLY.
    function automatic logic [7:0] ref_crc(input bit p[$], input int n);
        bit         a[$];
        logic [7:0] r;
        logic [7:0] o;
        a.delete();
        for (int i = 0; i < n; i++) a.push_back(p[i]);
        for (int i = 0; i < BITS; i++) a.push_back(1'b0);
        for (int i = 0; i < BITS; i++) a[i] = a[i] ^ INIT[BITS-1-i];
        for (int i = 0; i < n; i++) begin
            if (a[i]) begin
                a[i] = 1'b0;
                for (int j = 1; j <= BITS; j++) a[i+j] = a[i+j] ^ POLY[BITS-j];
            end
        end
        for (int k = 0; k < BITS; k++) r[BITS-1-k] = a[n+k];
        o = r;
        if (REF_OUT) begin
            for (int k = 0; k < BITS; k++) o[k] = r[BITS-1-k];
        end
        return o ^ XOR_OUT;
    endfunction

    task automatic eval_frame();
        int n;
        int lo;
        n = cur.size();
        lo = (n > BITS) ? n - BITS : 0;
        p_rx = 8'h00;
        for (int i = lo; i < n; i++) p_rx = {p_rx[6:0], cur[i]};
        p_runt = (n < BITS);
        p_calc = ref_crc(cur, p_runt ? 0 : n - BITS);
        p_ok = !p_runt && (p_rx == p_calc);
    endtask

    // Model: tracks frames as bit lists and publishes results two edges after eof.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                in_frame = 1'b0;
                cur.delete();
                pend = 1'b0;
                e_done = 1'b0;
                e_ok = 1'b0;
                e_runt = 1'b0;
                e_rx = 8'h00;
                e_calc = 8'h00;
                e_good = 0;
                e_bad = 0;
            end else begin
                e_done = 1'b0;
                if (pend) begin
                    e_done = 1'b1;
                    e_ok = p_ok;
                    e_runt = p_runt;
                    e_rx = p_rx;
                    e_calc = p_calc;
                    if (p_ok) e_good = (e_good < 65535) ? e_good + 1 : e_good;
                    else e_bad = (e_bad < 65535) ? e_bad + 1 : e_bad;
                    pend = 1'b0;
                end
                if (in_valid && in_sof) begin
                    cur.delete();
                    cur.push_back(in_data);
                    in_frame = 1'b1;
                end else if (in_valid && in_frame) begin
                    cur.push_back(in_data);
                end
                if (in_valid && in_frame && in_eof) begin
                    eval_frame();
                    pend = 1'b1;
                    in_frame = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) n_done++;
            if (chk_en) begin
                chk("frame_done", 32'(frame_done), 32'(e_done));
                chk("crc_ok", 32'(crc_ok), 32'(e_ok));
                chk("runt", 32'(runt), 32'(e_runt));
                chk("crc_rx", 32'(crc_rx), 32'(e_rx));
                chk("crc_calc", 32'(crc_calc), 32'(e_calc));
`ifdef CRC_FRAME_CHECKER_STATS_EN
                chk("good_cnt", 32'(good_cnt), 32'(e_good));
                chk("bad_cnt", 32'(bad_cnt), 32'(e_bad));
`endif
            end
        end
    end

    task automatic drive(input bit d, input bit s, input bit e);
        in_valid = 1'b1;
        in_data = d;
        in_sof = s;
        in_eof = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data = 1'($urandom);
        in_sof = 1'($urandom);
        in_eof = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send_range(input int lo, input int hi, input bit eof_last, input int gap);
        for (int i = lo; i <= hi; i++) begin
            if (int'($urandom_range(99)) < gap) begin
                repeat ($urandom_range(1, 3)) idle();
            end
            drive(fr[i], i == 0, eof_last && (i == hi));
        end
    endtask

    task automatic build_frame(input int n);
        logic [7:0] c;
        fr.delete();
        for (int i = 0; i < n; i++) fr.push_back(1'($urandom));
        c = ref_crc(fr, n);
        for (int k = BITS - 1; k >= 0; k--) fr.push_back(c[k]);
    endtask

    task automatic build_string();
        logic [7:0] b;
        fr.delete();
        for (int k = 0; k < 9; k++) begin
            b = 8'h31 + 8'(k);
            for (int j = 0; j < 8; j++) fr.push_back(b[j]);
        end
    endtask

    task automatic append_byte_msb(input logic [7:0] v);
        for (int k = 7; k >= 0; k--) fr.push_back(v[k]);
    endtask

    task automatic pulse_rst();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int d0;
    int nb;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 1'b0;
        in_sof = 1'b0;
        in_eof = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ok", 32'(crc_ok), 32'd0);
        chk("rst_calc", 32'(crc_calc), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        build_string();
        chk("model_check_value", 32'(ref_crc(fr, 72)), 32'h25);
        chk("model_empty", 32'(ref_crc(fr, 0)), 32'h00);
        append_byte_msb(8'h25);
        d0 = n_done;
        send_range(0, fr.size() - 1, 1'b1, 0);
        repeat (4) idle();
        chk("str_done_cnt", 32'(n_done - d0), 32'd1);
        chk("str_ok", 32'(crc_ok), 32'd1);
        chk("str_rx", 32'(crc_rx), 32'h25);
        chk("str_calc", 32'(crc_calc), 32'h25);

        fr[10] = ~fr[10];
        d0 = n_done;
        send_range(0, fr.size() - 1, 1'b1, 20);
        repeat (4) idle();
        chk("flip_done_cnt", 32'(n_done - d0), 32'd1);
        chk("flip_ok", 32'(crc_ok), 32'd0);
        chk("flip_runt", 32'(runt), 32'd0);
        chk_ne("flip_calc", 32'(crc_calc), 32'h25);
`ifdef CRC_FRAME_CHECKER_STATS_EN
        chk("flip_bad_cnt", 32'(bad_cnt), 32'd1);
`endif

        d0 = n_done;
        for (int f = 0; f < 3; f++) begin
            build_frame($urandom_range(1, 30));
            send_range(0, fr.size() - 1, 1'b1, (f == 1) ? 0 : 30);
        end
        repeat (4) idle();
        chk("b2b_done_cnt", 32'(n_done - d0), 32'd3);
        chk("b2b_ok", 32'(crc_ok), 32'd1);
`ifdef CRC_FRAME_CHECKER_STATS_EN
        chk("b2b_good_cnt", 32'(good_cnt), 32'd4);
`endif

        build_frame(0);
        send_range(0, fr.size() - 1, 1'b1, 0);
        repeat (3) idle();
        chk("empty_ok", 32'(crc_ok), 32'd1);
        chk("empty_calc", 32'(crc_calc), 32'h00);

        fr.delete();
        for (int i = 0; i < 5; i++) fr.push_back(1'($urandom));
        send_range(0, 4, 1'b1, 0);
        repeat (3) idle();
        chk("runt5_runt", 32'(runt), 32'd1);
        chk("runt5_ok", 32'(crc_ok), 32'd0);
        drive(1'b1, 1'b1, 1'b1);
        repeat (3) idle();
        chk("runt1_runt", 32'(runt), 32'd1);
        chk("runt1_ok", 32'(crc_ok), 32'd0);

        d0 = n_done;
        build_frame(40);
        send_range(0, 29, 1'b0, 10);
        build_frame(20);
        send_range(0, fr.size() - 1, 1'b1, 10);
        repeat (4) idle();
        chk("abort_done_cnt", 32'(n_done - d0), 32'd1);
        chk("abort_ok", 32'(crc_ok), 32'd1);

        d0 = n_done;
        build_frame(50);
        send_range(0, 39, 1'b0, 10);
        pulse_rst();
        for (int i = 0; i < 6; i++) drive(1'($urandom), 1'b0, 1'b1);
        repeat (4) idle();
        chk("rst_mid_done_cnt", 32'(n_done - d0), 32'd0);
        chk("rst_mid_ok", 32'(crc_ok), 32'd0);
        chk("rst_mid_rx", 32'(crc_rx), 32'd0);
        chk("rst_mid_calc", 32'(crc_calc), 32'd0);

        for (int f = 0; f < 60; f++) begin
            nb = $urandom_range(99);
            if (nb < 10) begin
                fr.delete();
                for (int i = 0; i < int'($urandom_range(1, 7)); i++) fr.push_back(1'($urandom));
            end else begin
                build_frame($urandom_range(0, 24));
                if ($urandom_range(99) < 25) begin
                    nb = $urandom_range(0, fr.size() - 1);
                    fr[nb] = ~fr[nb];
                end
            end
            if ($urandom_range(99) < 10 && fr.size() > 2) begin
                send_range(0, fr.size() - 2, 1'b0, 20);
            end
            if ($urandom_range(99) < 5) pulse_rst();
            send_range(0, fr.size() - 1, 1'b1, $urandom_range(0, 40));
            repeat ($urandom_range(0, 2)) idle();
        end
        repeat (4) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
